// File: rtl/mod_mem_cache_2way.sv
// mod_mem_cache_2way
//   Two-way set-associative, write-through, no-write-allocate cache placed
//   between the CPU load/store/fetch units and the memory bus adapter.
//   Per-set LRU victim choice, byte-merging write hits, walking flush and
//   saturating read hit/miss counters. Aborted requests never raise stb_o.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   abort_i                  abandon current/pending request
//   flush_i                  invalidate all lines (sampled in IDLE)
//   address_i, writedata_i   request address (bits [1:0] ignored) and data
//   read_i, write_i          request strobes (sampled in IDLE)
//   byteenable_i             byte lanes of the request
//   readdata_o, address_o    data/address of the last completed request
//   stb_o                    one-cycle completion pulse
//   busy_o                   high whenever not IDLE
//   hit_count_o/miss_count_o saturating read hit/miss counters
//   memory_*                 memory bus request/response
module mod_mem_cache_2way #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SETS = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              abort_i,
  input  logic              flush_i,
  input  logic [XLEN-1:0]   address_i,
  input  logic [XLEN-1:0]   writedata_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [XLEN/8-1:0] byteenable_i,
  output logic [XLEN-1:0]   readdata_o,
  output logic [XLEN-1:0]   address_o,
  output logic              stb_o,
  output logic              busy_o,
  output logic [31:0]       hit_count_o,
  output logic [31:0]       miss_count_o,
  input  logic [XLEN-1:0]   memory_readdata_i,
  input  logic              memory_operation_stb_i,
  output logic [XLEN-1:0]   memory_address_o,
  output logic [XLEN-1:0]   memory_writedata_o,
  output logic              memory_read_o,
  output logic              memory_write_o,
  output logic [XLEN/8-1:0] memory_byteenable_o
);

  localparam int unsigned IDX = $clog2(SETS);
  localparam int unsigned TAG = XLEN - IDX - 2;
  localparam int unsigned BEW = XLEN / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_WRITE,
    S_ABORT,
    S_DONE,
    S_FLUSH
  } state_t;

  state_t r_state;
  state_t w_next;

  // Storage: two ways per set; r_lru names the least-recently-used way.
  logic [SETS-1:0] r_valid0;
  logic [SETS-1:0] r_valid1;
  logic [SETS-1:0] r_lru;
  logic [TAG-1:0]  r_tag0  [SETS];
  logic [TAG-1:0]  r_tag1  [SETS];
  logic [XLEN-1:0] r_data0 [SETS];
  logic [XLEN-1:0] r_data1 [SETS];

  // Outstanding memory request
  logic [XLEN-1:0] r_req_addr;
  logic [XLEN-1:0] r_req_wdata;
  logic [BEW-1:0]  r_req_be;
  logic            r_req_rd;
  logic            r_req_wr;

  logic [XLEN-1:0] r_readdata;
  logic [XLEN-1:0] r_address;
  logic [31:0]     r_hits;
  logic [31:0]     r_misses;
  logic [IDX-1:0]  r_flush_set;

  // Lookup of the incoming request (IDLE)
  logic [IDX-1:0]  w_in_idx;
  logic [TAG-1:0]  w_in_tag;
  logic            w_in_hit0;
  logic            w_in_hit1;
  logic            w_in_hit;
  logic [XLEN-1:0] w_in_data;

  // Lookup of the outstanding request (memory completion)
  logic [IDX-1:0]  w_rq_idx;
  logic [TAG-1:0]  w_rq_tag;
  logic            w_rq_hit0;
  logic            w_rq_hit1;
  logic            w_victim;
  logic [XLEN-1:0] w_merged;

  logic w_mem_done;
  logic w_done_from_mem;
  logic w_start_flush;
  logic w_start_write;
  logic w_start_read;

  assign w_in_idx  = address_i[IDX+1:2];
  assign w_in_tag  = address_i[XLEN-1:IDX+2];
  assign w_in_hit0 = r_valid0[w_in_idx] && (r_tag0[w_in_idx] == w_in_tag);
  assign w_in_hit1 = r_valid1[w_in_idx] && (r_tag1[w_in_idx] == w_in_tag);
  assign w_in_hit  = w_in_hit0 || w_in_hit1;
  assign w_in_data = w_in_hit0 ? r_data0[w_in_idx] : r_data1[w_in_idx];

  assign w_rq_idx  = r_req_addr[IDX+1:2];
  assign w_rq_tag  = r_req_addr[XLEN-1:IDX+2];
  assign w_rq_hit0 = r_valid0[w_rq_idx] && (r_tag0[w_rq_idx] == w_rq_tag);
  assign w_rq_hit1 = r_valid1[w_rq_idx] && (r_tag1[w_rq_idx] == w_rq_tag);

  // First invalid way (way0 first), otherwise the LRU way.
  assign w_victim = !r_valid0[w_rq_idx] ? 1'b0 :
                    !r_valid1[w_rq_idx] ? 1'b1 : r_lru[w_rq_idx];

  // The array is updated on any memory completion, aborted or not.
  assign w_mem_done = memory_operation_stb_i &&
                      (r_state == S_MISS || r_state == S_WRITE || r_state == S_ABORT);
  assign w_done_from_mem = memory_operation_stb_i && !abort_i &&
                           (r_state == S_MISS || r_state == S_WRITE);

  always_comb begin
    w_merged = w_rq_hit0 ? r_data0[w_rq_idx] : r_data1[w_rq_idx];
    for (int unsigned b = 0; b < BEW; b++) begin
      if (r_req_be[b]) begin
        w_merged[8*b +: 8] = r_req_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_start_flush = 1'b0;
    w_start_write = 1'b0;
    w_start_read  = 1'b0;
    stb_o         = 1'b0;
    busy_o        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (abort_i) begin
          w_next = S_IDLE;
        end else if (flush_i) begin
          w_next        = S_FLUSH;
          w_start_flush = 1'b1;
        end else if (write_i) begin
          w_next        = S_WRITE;
          w_start_write = 1'b1;
        end else if (read_i) begin
          w_start_read = 1'b1;
          w_next       = w_in_hit ? S_DONE : S_MISS;
        end
      end
      S_MISS, S_WRITE: begin
        if (memory_operation_stb_i) begin
          w_next = abort_i ? S_IDLE : S_DONE;
        end else if (abort_i) begin
          w_next = S_ABORT;
        end
      end
      S_ABORT: begin
        if (memory_operation_stb_i) begin
          w_next = S_IDLE;
        end
      end
      S_DONE: begin
        stb_o  = 1'b1;
        w_next = S_IDLE;
      end
      S_FLUSH: begin
        if (r_flush_set == IDX'(SETS - 1)) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Control state: valid/LRU bits, request registers, results, counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid0    <= '0;
      r_valid1    <= '0;
      r_lru       <= '0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_req_be    <= '0;
      r_req_rd    <= 1'b0;
      r_req_wr    <= 1'b0;
      r_readdata  <= '0;
      r_address   <= '0;
      r_hits      <= '0;
      r_misses    <= '0;
      r_flush_set <= '0;
    end else begin
      if (w_start_write) begin
        r_req_addr  <= address_i;
        r_req_wdata <= writedata_i;
        r_req_be    <= byteenable_i;
        r_req_wr    <= 1'b1;
        r_req_rd    <= 1'b0;
      end

      if (w_start_read) begin
        if (w_in_hit) begin
          r_readdata        <= w_in_data;
          r_address         <= address_i;
          r_lru[w_in_idx]   <= w_in_hit0;
          if (r_hits != '1) begin
            r_hits <= r_hits + 32'd1;
          end
        end else begin
          r_req_addr  <= address_i;
          r_req_wdata <= '0;
          r_req_be    <= byteenable_i;
          r_req_rd    <= 1'b1;
          r_req_wr    <= 1'b0;
          if (r_misses != '1) begin
            r_misses <= r_misses + 32'd1;
          end
        end
      end

      if (w_start_flush) begin
        r_flush_set <= '0;
      end
      if (r_state == S_FLUSH) begin
        r_valid0[r_flush_set] <= 1'b0;
        r_valid1[r_flush_set] <= 1'b0;
        r_lru[r_flush_set]    <= 1'b0;
        r_flush_set           <= r_flush_set + 1'b1;
      end

      if (w_mem_done) begin
        r_req_rd <= 1'b0;
        r_req_wr <= 1'b0;
        if (r_req_rd) begin
          if (w_victim) begin
            r_valid1[w_rq_idx] <= 1'b1;
          end else begin
            r_valid0[w_rq_idx] <= 1'b1;
          end
          r_lru[w_rq_idx] <= ~w_victim;
        end else if (r_req_wr && (w_rq_hit0 || w_rq_hit1)) begin
          r_lru[w_rq_idx] <= w_rq_hit0;
        end
      end

      if (w_done_from_mem) begin
        r_readdata <= r_req_rd ? memory_readdata_i : '0;
        r_address  <= r_req_addr;
      end
    end
  end

  // Tag/data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (w_mem_done) begin
      if (r_req_rd) begin
        if (w_victim) begin
          r_tag1[w_rq_idx]  <= w_rq_tag;
          r_data1[w_rq_idx] <= memory_readdata_i;
        end else begin
          r_tag0[w_rq_idx]  <= w_rq_tag;
          r_data0[w_rq_idx] <= memory_readdata_i;
        end
      end else if (r_req_wr) begin
        if (w_rq_hit0) begin
          r_data0[w_rq_idx] <= w_merged;
        end else if (w_rq_hit1) begin
          r_data1[w_rq_idx] <= w_merged;
        end
      end
    end
  end

  assign readdata_o          = r_readdata;
  assign address_o           = r_address;
  assign hit_count_o         = r_hits;
  assign miss_count_o        = r_misses;
  assign memory_address_o    = r_req_addr;
  assign memory_writedata_o  = r_req_wdata;
  assign memory_byteenable_o = r_req_be;
  assign memory_read_o       = r_req_rd;
  assign memory_write_o      = r_req_wr;

endmodule

// File: tb/tb_mod_mem_cache_2way.sv
// Testbench for mod_mem_cache_2way (XLEN=32, SETS=32).
// Every issued request pushes its expected {readdata, address} into a
// queue; a negedge monitor pops and compares on every stb_o pulse.
module tb_mod_mem_cache_2way;

  localparam int unsigned XLEN = 32;
  localparam int unsigned SETS = 32;

  logic            clk_i;
  logic            rst_ni;
  logic            abort_i;
  logic            flush_i;
  logic [XLEN-1:0] address_i;
  logic [XLEN-1:0] writedata_i;
  logic            read_i;
  logic            write_i;
  logic [3:0]      byteenable_i;
  logic [XLEN-1:0] readdata_o;
  logic [XLEN-1:0] address_o;
  logic            stb_o;
  logic            busy_o;
  logic [31:0]     hit_count_o;
  logic [31:0]     miss_count_o;
  logic [XLEN-1:0] memory_readdata_i;
  logic            memory_operation_stb_i;
  logic [XLEN-1:0] memory_address_o;
  logic [XLEN-1:0] memory_writedata_o;
  logic            memory_read_o;
  logic            memory_write_o;
  logic [3:0]      memory_byteenable_o;

  mod_mem_cache_2way #(
    .XLEN(XLEN),
    .SETS(SETS)
  ) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .abort_i               (abort_i),
    .flush_i               (flush_i),
    .address_i             (address_i),
    .writedata_i           (writedata_i),
    .read_i                (read_i),
    .write_i               (write_i),
    .byteenable_i          (byteenable_i),
    .readdata_o            (readdata_o),
    .address_o             (address_o),
    .stb_o                 (stb_o),
    .busy_o                (busy_o),
    .hit_count_o           (hit_count_o),
    .miss_count_o          (miss_count_o),
    .memory_readdata_i     (memory_readdata_i),
    .memory_operation_stb_i(memory_operation_stb_i),
    .memory_address_o      (memory_address_o),
    .memory_writedata_o    (memory_writedata_o),
    .memory_read_o         (memory_read_o),
    .memory_write_o        (memory_write_o),
    .memory_byteenable_o   (memory_byteenable_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every completion must match the oldest expected response.
  always @(negedge clk_i) begin
    if (rst_ni && stb_o) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_stb: got stb_o with data %h addr %h, required no completion",
                 readdata_o, address_o);
      end else begin
        mon_e = sb_q.pop_front();
        if (readdata_o !== mon_e.data || address_o !== mon_e.addr) begin
          n_errors++;
          $display("FAIL completion: got data %h addr %h, required data %h addr %h",
                   readdata_o, address_o, mon_e.data, mon_e.addr);
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy_o; i++) begin
      @(posedge clk_i); #1;
    end
    if (busy_o) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout: got busy_o 1, required 0 within 60 cycles");
    end
  endtask

  task automatic wait_sb(input string name);
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) begin
      @(posedge clk_i); #1;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got %0d pending completions, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  // Called one #1 after the accepting edge; answers after lat cycles of request.
  task automatic mem_respond(input int lat, input logic [31:0] mdata, input string name);
    int hi;
    hi = 0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk_i);
      if (memory_read_o || memory_write_o) hi++;
      if (i == lat - 1) begin
        memory_readdata_i      = mdata;
        memory_operation_stb_i = 1'b1;
      end
    end
    @(posedge clk_i); #1;
    memory_operation_stb_i = 1'b0;
    memory_readdata_i      = '0;
    chk({name, "_mem_cycles"}, 32'(hi), 32'(lat));
    chk({name, "_mem_drop"}, {31'b0, memory_read_o | memory_write_o}, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input bit hit, input int lat,
                         input logic [31:0] mdata, input logic [31:0] expd, input string name);
    exp_t e;
    wait_idle();
    e.data = expd;
    e.addr = addr;
    sb_q.push_back(e);
    address_i    = addr;
    byteenable_i = 4'hF;
    read_i       = 1'b1;
    @(posedge clk_i); #1;
    read_i = 1'b0;
    if (hit) begin
      chk({name, "_hit_stb"}, {31'b0, stb_o}, 32'd1);
    end else begin
      chk({name, "_maddr"}, memory_address_o, addr);
      mem_respond(lat, mdata, name);
    end
    wait_sb(name);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input int lat, input string name);
    exp_t e;
    wait_idle();
    e.data = '0;
    e.addr = addr;
    sb_q.push_back(e);
    address_i    = addr;
    writedata_i  = data;
    byteenable_i = be;
    write_i      = 1'b1;
    @(posedge clk_i); #1;
    write_i = 1'b0;
    chk({name, "_mwdata"}, memory_writedata_o, data);
    chk({name, "_mbe"}, {28'b0, memory_byteenable_o}, {28'b0, be});
    mem_respond(lat, 32'h0, name);
    wait_sb(name);
  endtask

  initial begin
    int busy_cycles;
    rst_ni                 = 1'b0;
    abort_i                = 1'b0;
    flush_i                = 1'b0;
    address_i              = '0;
    writedata_i            = '0;
    read_i                 = 1'b0;
    write_i                = 1'b0;
    byteenable_i           = '0;
    memory_readdata_i      = '0;
    memory_operation_stb_i = 1'b0;

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_stb", {31'b0, stb_o}, 32'd0);
    chk("rst_readdata", readdata_o, 32'd0);
    chk("rst_hits", hit_count_o, 32'd0);
    chk("rst_misses", miss_count_o, 32'd0);
    chk("rst_mread", {31'b0, memory_read_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Miss with 3-cycle memory latency, then a 1-cycle hit
    do_read(32'h100, 1'b0, 3, 32'hDEADBEEF, 32'hDEADBEEF, "rd100_miss");
    chk("misses_1", miss_count_o, 32'd1);
    do_read(32'h100, 1'b1, 0, 32'h0, 32'hDEADBEEF, "rd100_hit");
    chk("hits_1", hit_count_o, 32'd1);

    // LRU in set 0 (0x100 already in way0)
    do_read(32'h000, 1'b0, 1, 32'h0000AAAA, 32'h0000AAAA, "rd000_miss");
    do_read(32'h080, 1'b0, 2, 32'h08080808, 32'h08080808, "rd080_miss");
    do_read(32'h000, 1'b1, 0, 32'h0, 32'h0000AAAA, "rd000_hit");
    do_read(32'h100, 1'b0, 1, 32'h10101010, 32'h10101010, "rd100_refill");
    do_read(32'h000, 1'b1, 0, 32'h0, 32'h0000AAAA, "rd000_kept");
    do_read(32'h080, 1'b0, 1, 32'h0808F00D, 32'h0808F00D, "rd080_evicted");
    chk("hits_lru", hit_count_o, 32'd3);
    chk("misses_lru", miss_count_o, 32'd5);

    // Byte-merging write hit, and a non-allocating write miss
    do_read(32'h040, 1'b0, 2, 32'h11223344, 32'h11223344, "rd040_miss");
    do_write(32'h040, 32'hAABBCCDD, 4'b0101, 2, "wr040");
    do_read(32'h040, 1'b1, 0, 32'h0, 32'h11BB33DD, "rd040_merged");
    do_write(32'h044, 32'h01020304, 4'hF, 1, "wr044");
    do_read(32'h044, 1'b0, 1, 32'h44444444, 32'h44444444, "rd044_noalloc");
    chk("hits_wr", hit_count_o, 32'd4);
    chk("misses_wr", miss_count_o, 32'd7);

    // abort_i in IDLE wins over read_i
    wait_idle();
    address_i = 32'h00C;
    read_i    = 1'b1;
    abort_i   = 1'b1;
    @(posedge clk_i); #1;
    read_i  = 1'b0;
    abort_i = 1'b0;
    chk("idle_abort_busy", {31'b0, busy_o}, 32'd0);
    chk("idle_abort_mread", {31'b0, memory_read_o}, 32'd0);

    // Abort of an in-flight miss: no stb_o, line still filled
    wait_idle();
    address_i = 32'h008;
    read_i    = 1'b1;
    @(posedge clk_i); #1;
    read_i  = 1'b0;
    abort_i = 1'b1;
    chk("abort_mread", {31'b0, memory_read_o}, 32'd1);
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    @(posedge clk_i); #1;
    memory_readdata_i      = 32'h0B0B0B0B;
    memory_operation_stb_i = 1'b1;
    chk("abort_busy_wait", {31'b0, busy_o}, 32'd1);
    @(posedge clk_i); #1;
    memory_operation_stb_i = 1'b0;
    memory_readdata_i      = '0;
    chk("abort_busy_fall", {31'b0, busy_o}, 32'd0);
    chk("abort_no_stb", {31'b0, stb_o}, 32'd0);
    do_read(32'h008, 1'b1, 0, 32'h0, 32'h0B0B0B0B, "rd008_after_abort");
    chk("hits_abort", hit_count_o, 32'd5);
    chk("misses_abort", miss_count_o, 32'd8);

    // Flush: busy for SETS cycles, counters untouched, lines gone
    wait_idle();
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i     = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 100 && busy_o; i++) begin
      busy_cycles++;
      @(posedge clk_i); #1;
    end
    chk("flush_busy_cycles", 32'(busy_cycles), 32'(SETS));
    chk("flush_hits_kept", hit_count_o, 32'd5);
    chk("flush_misses_kept", miss_count_o, 32'd8);
    do_read(32'h000, 1'b0, 1, 32'h0000AAAA, 32'h0000AAAA, "rd000_flushed");
    do_read(32'h040, 1'b0, 1, 32'h11BB33DD, 32'h11BB33DD, "rd040_flushed");
    do_read(32'h008, 1'b0, 1, 32'h0B0B0B0B, 32'h0B0B0B0B, "rd008_flushed");
    chk("misses_flush", miss_count_o, 32'd11);

    // Reset in the middle of a write
    wait_idle();
    address_i    = 32'h080;
    writedata_i  = 32'h12345678;
    byteenable_i = 4'hF;
    write_i      = 1'b1;
    @(posedge clk_i); #1;
    write_i = 1'b0;
    chk("midwr_mwrite", {31'b0, memory_write_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("midwr_mwrite_drop", {31'b0, memory_write_o}, 32'd0);
    chk("midwr_busy", {31'b0, busy_o}, 32'd0);
    chk("midwr_readdata", readdata_o, 32'd0);
    chk("midwr_address", address_o, 32'd0);
    chk("midwr_maddr", memory_address_o, 32'd0);
    chk("midwr_mwdata", memory_writedata_o, 32'd0);
    chk("midwr_mbe", {28'b0, memory_byteenable_o}, 32'd0);
    chk("midwr_hits", hit_count_o, 32'd0);
    chk("midwr_misses", miss_count_o, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    do_read(32'h000, 1'b0, 1, 32'h00005555, 32'h00005555, "rd000_after_rst");
    chk("misses_after_rst", miss_count_o, 32'd1);

    repeat (3) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mod_mem_cache_2way.md
# mod_mem_cache_2way

Parametrised two-way set-associative write-through cache sitting between the CPU load/store and fetch units and the memory bus adapter. It generalises the current direct-mapped cache: set count is a parameter, partial (byte-enabled) write hits merge into the cached word instead of invalidating it, and victims are chosen by per-set LRU. It also adds a walking flush and saturating hit/miss counters, and fixes abort so that no `stb_o` is produced for an aborted request.

## Interface
- `XLEN`, 32, data/address width; a multiple of 8.
- `SETS`, 32, number of sets; a power of two, ≥2. `IDX = log2(SETS)`, `TAG = XLEN-IDX-2`.
- `clk_i` in 1, single clock.
- `rst_ni` in 1, reset, asynchronous and active-low.
- `abort_i` in 1, abandon the current or pending request.
- `flush_i` in 1, invalidate all lines. Sampled only in IDLE.
- `address_i`, `writedata_i` in XLEN, request address (word-aligned; bits [1:0] ignored) and write data.
- `read_i`, `write_i` in 1, request strobes. Sampled only in IDLE.
- `byteenable_i` in XLEN/8, byte lanes for the request.
- `readdata_o`, `address_o` out XLEN, result data and address of the completed request.
- `stb_o` out 1, one-cycle completion pulse.
- `busy_o` out 1, high whenever state ≠ IDLE.
- `hit_count_o`, `miss_count_o` out 32, saturating read hit/miss counters.
- `memory_readdata_i` in XLEN; `memory_operation_stb_i` in 1, memory completion.
- `memory_address_o`, `memory_writedata_o` out XLEN.
- `memory_read_o`, `memory_write_o` out 1.
- `memory_byteenable_o` out XLEN/8.

## Operation
- Storage per set: two ways of {valid, tag[TAG], data[XLEN]}, plus one LRU bit naming the least-recently-used way.
- Index is `addr[IDX+1:2]`; tag is `addr[XLEN-1:IDX+2]`.
- States: IDLE, MISS, WRITE, ABORT, DONE, FLUSH.
- IDLE priority is abort_i > flush_i > write_i > read_i:
  - abort_i: stay in IDLE.
  - flush_i: go to FLUSH.
  - write_i: go to WRITE.
  - read_i with a hit in either way: go to DONE, and the LRU bit points to the other way.
  - read_i with a miss: go to MISS.
- MISS and WRITE: memory request registers are loaded from the inputs on entry and held constant until `memory_operation_stb_i`.
  - MISS drives read=1, writedata=0.
  - WRITE drives write=1, writedata=writedata_i.
  - byteenable = byteenable_i in both.
- Cache update happens whenever memory completes, in MISS, WRITE or ABORT, regardless of abort:
  - Read fill: victim is the first invalid way (way0 first), otherwise the LRU way. Write tag, data and valid=1; LRU then points to the other way.
  - Write hit: merge writedata into the hit way's data per enabled byte; LRU then points to the other way.
  - Write miss: no allocate.
- MISS/WRITE on memory stb with abort_i low: go to DONE. On memory stb with abort_i high: go to IDLE, no stb_o.
- MISS/WRITE on abort_i alone: go to ABORT. ABORT waits for memory stb, then goes to IDLE; no stb_o.
- DONE lasts one cycle, then IDLE. stb_o=1 only in DONE.
  - On DONE entry, readdata_o is loaded with the hit data (hit), memory_readdata_i (miss) or 0 (write).
  - On DONE entry, address_o is loaded with the request address.
  - Both hold their values until the next DONE entry.
- FLUSH: a set counter runs 0..SETS-1, clearing both valid bits and the LRU bit of one set per cycle. After set SETS-1 it returns to IDLE. flush_i and abort_i are ignored during FLUSH.
- Counters update on the IDLE transition of a read request: a hit increments `hit_count_o`, a miss increments `miss_count_o`. Both saturate at 2^32-1. Writes are not counted; flush does not clear the counters.
- Asynchronous reset (rst_ni low) sets:
  - state to IDLE;
  - all valid and LRU bits, request registers, readdata_o, address_o and both counters to 0.
- Reset in the middle of a memory transaction drops the request lines immediately; the cache does not wait for the memory response.

## Timing
- Read hit: request in cycle N; stb_o and data in cycle N+1. busy_o is high in N+1 only.
- Miss or write: memory_* outputs are valid from N+1. If memory_operation_stb_i is sampled in cycle M, stb_o is high in M+1 and the cache array is updated at the M+1 edge.
- A request accepted in IDLE at cycle N: its readdata is stable only while stb_o is high. A new request may be presented in the cycle after DONE, when the state is IDLE again.
- Flush: busy_o is high for exactly SETS cycles.
- A read issued the cycle after a write's DONE sees the merged data.

## Test plan
- Reset, then read 0x100 with memory returning 0xDEADBEEF after 3 cycles. Required: memory_read_o high for 3 cycles, stb_o one cycle later with 0xDEADBEEF; miss_count_o=1. A repeat read hits in 1 cycle with hit_count_o=1.
- SETS=32. Read 0x000, 0x080, 0x000, then 0x100 (all map to set 0). Required: 0x080 is evicted (LRU) and 0x000 still hits.
- Cached word 0x11223344 at 0x40; write 0xAABBCCDD with byteenable 4'b0101. Required: the next read hits and returns 0x11BB33DD.
- Miss in flight, abort_i pulsed; memory completes 2 cycles later. Required: no stb_o, busy_o falls the cycle after memory stb, and the line is filled (a later read hits).
- Fill 3 lines, then flush_i. Required: busy_o high for 32 cycles and all three addresses miss afterwards; the counters are unchanged by the flush.
- Assert rst_ni low mid-WRITE. Required: memory_write_o drops immediately and all outputs are 0.
